lc4_wb_buffer: RTL
==================

Name: lc4_wb_buffer

Overview:
- Ordered writeback buffer that sits between the two-pipe execute/memory stages and the superscalar register file's two write ports.
- Accepts up to two completed results per cycle (pipe A older than pipe B) into a circular buffer.
- Drains up to two results per cycle, in program order, onto the regfile write ports.
- The older result always drives write port A and the younger drives port B, so the regfile's "pipe B wins" rule preserves program order.

Parameters:
- n, 16, data width of a result.
- DEPTH, 8, buffer entries; power of two, at least 4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- gwe  in  1  global write enable; when 0, no state changes.
- i_valid_A  in  1  pipe A result present.
- i_rd_A  in  3  pipe A destination register.
- i_wdata_A  in  n  pipe A result.
- i_we_A  in  1  pipe A writes a register.
- i_valid_B, i_rd_B, i_wdata_B, i_we_B  in  1/3/n/1  same fields for pipe B (younger).
- o_ready  out  1  at least 2 free entries this cycle.
- i_stall  in  1  hold the drain side this cycle.
- o_rd_A  out  3  write port A selector.
- o_wdata_A  out  n  write port A data.
- o_rd_we_A  out  1  write port A enable.
- o_rd_B, o_wdata_B, o_rd_we_B  out  3/n/1  same fields for write port B.
- o_count  out  log2(DEPTH)+1  occupied entries.
- o_empty  out  1  count == 0.
- o_full  out  1  count == DEPTH.
- i_lookup_rs  in  3  forwarding query register (feature port).
- o_hit  out  1  forwarding hit (feature port).
- o_hit_data  out  n  forwarding data (feature port).

Behaviour:
- Reset: head, tail and count go to 0; o_empty=1, o_full=0, o_ready=1, o_rd_we_A=o_rd_we_B=0. Stored entries are don't-care. Reset wins over any simultaneous enqueue or drain, and also applies mid-drain.
- Enqueue, on a rising edge with gwe=1 and o_ready=1:
  - An input with valid=1 and we=1 is stored at tail.
  - A is stored before B.
  - valid=1 with we=0 is discarded and uses no slot.
  - B alone is allowed.
  - Tail advances by the number stored (0, 1 or 2), modulo DEPTH.
  - With o_ready=0, inputs are ignored. The producer must stall; valids are not latched.
- o_ready = (DEPTH - count) >= 2, computed from the current count, not from the post-drain count.
- Drain outputs (combinational from head storage):
  - Port A shows entry[head]. Port B shows entry[head+1 mod DEPTH].
  - o_rd_we_A = (count>=1) & ~i_stall.
  - o_rd_we_B = (count>=2) & ~i_stall.
- Pop: on an edge with gwe=1 and ~i_stall, head advances by min(count,2).
- Latency: an entry stored on edge t appears on the write ports in cycle t+1 at the earliest. There is no input-to-output bypass.
- Simultaneous enqueue and drain: next count = count + stored - popped. A full buffer that drains 2 in a cycle still reports o_ready=0 that cycle.
- Two entries with the same rd drained together are both asserted; the regfile keeps port B, the younger entry.
- Pointers wrap at DEPTH with no bubble. Entry order across the wrap is preserved.
- gwe=0: pointers and count hold. Outputs still reflect head; the regfile ignores them under gwe=0.

Optional Feature:
- Macro: LC4_WB_BUFFER_FWD_EN.
- Defined:
  - o_hit=1 when any occupied entry has rd == i_lookup_rs.
  - o_hit_data is the data of the youngest such entry, searched from tail-1 back to head.
  - Purely combinational, evaluated on current contents. Entries being enqueued this cycle are not visible.
- Undefined: o_hit=0 and o_hit_data=0. The ports remain so the interface is identical.

Decomposition:
- Shared include lc4_wb_defs.vh holds:
  - register selector width (3);
  - pointer width function of DEPTH;
  - enqueue and pop count encodings.
- Storage uses existing Nbit_reg instances, with per-entry write enables gated by gwe.
- One natural sub-module: lc4_wb_ptr. It holds the head/tail/count registers, the modulo increment by 0/1/2, and the ready/empty/full derivation.

Test Plan:
- Reset, then idle:
  - o_empty=1, o_ready=1, o_rd_we_A=o_rd_we_B=0, o_count=0.
- Enqueue A(rd=3, data=16'h1111) and B(rd=3, data=16'h2222) with i_stall=1, then drop i_stall:
  - Next cycle port A = r3/1111 and port B = r3/2222, both enables high.
  - After the edge o_count=0, and the regfile reads r3=2222.
- Enqueue A(we=0) and B(rd=5, data=16'h00AB):
  - o_count=1.
  - Port A = r5/00AB, o_rd_we_B=0.
- Fill with stall held: 4 cycles of 2 entries (DEPTH=8):
  - o_full=1, o_ready=0.
  - A further enqueue of rd=7 is ignored, and o_count stays 8.
- Wrap: drain 6, enqueue 4, drain all:
  - Drained rd sequence matches the enqueue order exactly across the pointer wrap.
- FWD_EN: entries rd=2:16'h0001, then rd=2:16'h0002 pending, with i_lookup_rs=2:
  - o_hit=1, o_hit_data=16'h0002.
  - i_lookup_rs=4 gives o_hit=0.
  - Feature undefined: o_hit=0 always.

Source files
------------

// File: rtl/lc4_wb_buffer_pkg.sv
// Shared definitions for the LC4 ordered writeback buffer: selector width,
// pointer width helper and the 0/1/2 enqueue/pop count encoding.
package lc4_wb_buffer_pkg;

  localparam int RSEL_W = 3;

  typedef enum logic [1:0] {
    CNT_0 = 2'd0,
    CNT_1 = 2'd1,
    CNT_2 = 2'd2
  } cnt2_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/Nbit_reg.sv
// Generic n-bit register with local and global write enables.
module Nbit_reg #(
  parameter int n = 1,
  parameter logic [n-1:0] r = '0
) (
  input  logic [n-1:0] in,
  output logic [n-1:0] out,
  input  logic         clk,
  input  logic         we,
  input  logic         gwe,
  input  logic         rst
);

  always_ff @(posedge clk) begin
    if (rst)             out <= r;
    else if (gwe && we)  out <= in;
  end

endmodule

// File: rtl/lc4_wb_ptr.sv
// Head/tail/count bookkeeping for the writeback buffer; head pops min(count,2)
// when the drain side is not stalled, tail advances by the accepted count.
module lc4_wb_ptr
  import lc4_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = ptr_w(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gwe,
  input  cnt2_e         enq_num,
  input  logic          pop_en,
  output logic [PW-1:0] head,
  output logic [PW-1:0] tail,
  output logic [CW-1:0] count,
  output logic          ready,
  output logic          empty,
  output logic          full
);

  cnt2_e pop_num;

  always_comb begin
    pop_num = CNT_0;
    if (pop_en) begin
      if (count >= CW'(2))      pop_num = CNT_2;
      else if (count == CW'(1)) pop_num = CNT_1;
    end
  end

  // DEPTH is a power of two, so the pointer wrap is the natural PW-bit overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (gwe) begin
      head  <= head + PW'(pop_num);
      tail  <= tail + PW'(enq_num);
      count <= count + CW'(enq_num) - CW'(pop_num);
    end
  end

  assign ready = (CW'(DEPTH) - count) >= CW'(2);
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/lc4_wb_buffer.sv
// Ordered two-in/two-out writeback buffer feeding the regfile write ports.
// Optional forwarding lookup enabled by LC4_WB_BUFFER_FWD_EN.
module lc4_wb_buffer
  import lc4_wb_buffer_pkg::*;
#(
  parameter int n     = 16,
  parameter int DEPTH = 8,
  localparam int PW = ptr_w(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gwe,
  input  logic              i_valid_A,
  input  logic [RSEL_W-1:0] i_rd_A,
  input  logic [n-1:0]      i_wdata_A,
  input  logic              i_we_A,
  input  logic              i_valid_B,
  input  logic [RSEL_W-1:0] i_rd_B,
  input  logic [n-1:0]      i_wdata_B,
  input  logic              i_we_B,
  output logic              o_ready,
  input  logic              i_stall,
  output logic [RSEL_W-1:0] o_rd_A,
  output logic [n-1:0]      o_wdata_A,
  output logic              o_rd_we_A,
  output logic [RSEL_W-1:0] o_rd_B,
  output logic [n-1:0]      o_wdata_B,
  output logic              o_rd_we_B,
  output logic [CW-1:0]     o_count,
  output logic              o_empty,
  output logic              o_full,
  input  logic [RSEL_W-1:0] i_lookup_rs,
  output logic              o_hit,
  output logic [n-1:0]      o_hit_data
);

  localparam int EW = RSEL_W + n;

  logic [PW-1:0] head, tail, head_nxt, wr_ptr_b;
  logic [CW-1:0] count;
  logic          ready;
  logic          st_a, st_b;
  cnt2_e         enq_num;
  logic [EW-1:0] ent [DEPTH];

  // Only results that actually write a register take a slot.
  assign st_a = ready && i_valid_A && i_we_A;
  assign st_b = ready && i_valid_B && i_we_B;

  always_comb begin
    case ({st_a, st_b})
      2'b11:   enq_num = CNT_2;
      2'b00:   enq_num = CNT_0;
      default: enq_num = CNT_1;
    endcase
  end

  assign wr_ptr_b = st_a ? tail + PW'(1) : tail;

  lc4_wb_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .gwe     (gwe),
    .enq_num (enq_num),
    .pop_en  (~i_stall),
    .head    (head),
    .tail    (tail),
    .count   (count),
    .ready   (ready),
    .empty   (o_empty),
    .full    (o_full)
  );

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic hit_a, hit_b;
    assign hit_a = st_a && (tail == PW'(e));
    assign hit_b = st_b && (wr_ptr_b == PW'(e));

    // Entry contents are don't-care after reset, so storage is never reset.
    Nbit_reg #(.n(EW)) u_ent (
      .in  (hit_a ? {i_rd_A, i_wdata_A} : {i_rd_B, i_wdata_B}),
      .out (ent[e]),
      .clk (clk),
      .we  (gwe && (hit_a || hit_b)),
      .gwe (gwe),
      .rst (1'b0)
    );
  end

  assign head_nxt = head + PW'(1);

  assign {o_rd_A, o_wdata_A} = ent[head];
  assign {o_rd_B, o_wdata_B} = ent[head_nxt];
  assign o_rd_we_A = (count >= CW'(1)) && !i_stall;
  assign o_rd_we_B = (count >= CW'(2)) && !i_stall;
  assign o_ready   = ready;
  assign o_count   = count;

`ifdef LC4_WB_BUFFER_FWD_EN
  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (ent[head + PW'(k)][EW-1 -: RSEL_W] == i_lookup_rs)) begin
        o_hit      = 1'b1;
        o_hit_data = ent[head + PW'(k)][n-1:0];
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^i_lookup_rs;
  assign o_hit         = 1'b0;
  assign o_hit_data    = '0;
`endif

endmodule
